tcpc_regs_arbiter: RTL and testbench
====================================

// Module: tcpc_regs_arbiter
// PURPOSE
//  Two-requester arbiter for the single TCPC register-file access port (REQ/RNW/ADDR/WR_DATA/RD_DATA/ACK).
//  Shares the port between the I2C slave manager (TCPM side, port "tcpm") and local TCPC logic (port "lcl").
//  Round-robin grant, one transaction at a time, registered downstream request; ACK/RD_DATA routed to the owner.
// PARAMETERS
//  ADDR_W          8   register address width
//  DATA_W          8   register data width
//  TIMEOUT_CYCLES  16  max cycles BUSY waits for ACK_reg (used only with TCPC_ARB_TIMEOUT_EN)
// PORTS
//  CLK           in   1       clock, all logic on posedge
//  RESET_N       in   1       synchronous reset, active-low
//  REQ_tcpm      in   1       TCPM request, held high until ACK_tcpm
//  RNW_tcpm      in   1       1=read 0=write
//  ADDR_tcpm     in   ADDR_W  register address
//  WR_DATA_tcpm  in   DATA_W  write data
//  ACK_tcpm      out  1       one-cycle completion pulse to TCPM
//  RD_DATA_tcpm  out  DATA_W  read data, valid when ACK_tcpm=1
//  ERR_tcpm      out  1       timeout pulse (0 without macro)
//  REQ_lcl/RNW_lcl/ADDR_lcl/WR_DATA_lcl  in   as tcpm   local-logic request
//  ACK_lcl/RD_DATA_lcl/ERR_lcl           out  as tcpm   local-logic response
//  REQ_reg       out  1       request to register file
//  RNW_reg       out  1       direction to register file
//  ADDR_reg      out  ADDR_W  address to register file
//  WR_DATA_reg   out  DATA_W  write data to register file
//  RD_DATA_reg   in   DATA_W  read data from register file
//  ACK_reg       in   1       completion from register file
//  BUSY          out  1       1 while a transaction is granted (state BUSY)
//  OWNER         out  1       0=tcpm 1=lcl, valid when BUSY=1
// BEHAVIOUR
//  Reset (RESET_N=0 at posedge): state=IDLE, all outputs 0, last_owner=1 (tcpm wins first tie).
//  States: IDLE -> BUSY on any REQ; BUSY -> GAP on ACK_reg (or timeout); GAP -> IDLE unconditionally.
//  IDLE: only one REQ -> grant it; both -> grant the one != last_owner. Grant latches RNW/ADDR/WR_DATA
//   into *_reg outputs and sets REQ_reg=1 at the same edge (1-cycle latency REQ_x -> REQ_reg).
//  BUSY: REQ_reg held 1, *_reg outputs stable; upstream changes ignored. Granted request is committed:
//   owner dropping REQ early does not abort; ACK still forwarded.
//  ACK_x = ACK_reg & BUSY & (OWNER==x), combinational; RD_DATA_x = RD_DATA_reg when ACK_x else 0.
//  BUSY->GAP edge: REQ_reg=0, last_owner<=OWNER. GAP: no grant, so requester holding REQ one cycle
//   after ACK is not re-granted; requester must drop REQ in the cycle after ACK_x.
//  Back-to-back: ACK at n, GAP n+1, IDLE n+2, new REQ_reg at n+3 at the earliest.
//  Fairness: both requesting continuously -> strict alternation tcpm,lcl,tcpm,...
//  Reset mid-BUSY: REQ_reg drops at that edge, no ACK emitted, state IDLE.
// CONFIGURATION
//  `TCPC_ARB_TIMEOUT_EN defined: counter cleared on grant, +1 per BUSY cycle; reaching TIMEOUT_CYCLES
//   without ACK_reg -> ERR_x one-cycle pulse to owner, REQ_reg=0, state GAP. ACK_reg in the expiry cycle
//   wins (ACK, no ERR).
//  Undefined: no counter, ERR_tcpm=ERR_lcl=0 constant, BUSY waits indefinitely for ACK_reg.
// STRUCTURE
//  Shared package tcpc_arb_pkg: state localparams (IDLE/BUSY/GAP), OWNER encodings (OWN_TCPM=0, OWN_LCL=1).
//  Sub-module tcpc_rr_pick: combinational 2-way round-robin picker (req[1:0], last_owner -> grant_valid, grant_id).
//  Top holds FSM, output registers, ACK/data routing, optional timeout counter.
// TESTING
//  1 tcpm write only: REQ_tcpm=1 RNW=0 ADDR=0x10 WR=0xA5; reg ACK after 2 cycles -> REQ_reg next cycle
//    with ADDR_reg=0x10 WR_DATA_reg=0xA5, one ACK_tcpm pulse, ACK_lcl=0.
//  2 lcl read: ADDR_lcl=0x1D, RD_DATA_reg=0x3C with ACK_reg -> ACK_lcl=1 RD_DATA_lcl=0x3C, RD_DATA_tcpm=0.
//  3 both REQ at reset exit, held -> grants tcpm, lcl, tcpm in order; REQ_reg low in each GAP cycle.
//  4 requester holds REQ 1 cycle after ACK -> no second grant; exactly one REQ_reg transaction.
//  5 RESET_N=0 during BUSY -> next edge REQ_reg=0 BUSY=0, no ACK_x; later REQ grants normally.
//  6 macro on, TIMEOUT_CYCLES=4, ACK_reg never -> ERR_tcpm pulse 4 cycles after grant; ACK_reg on
//    expiry cycle -> ACK_tcpm, ERR_tcpm=0.

Source files
------------

// File: rtl/tcpc_arb_pkg.sv
// Shared definitions for the TCPC register-port arbiter.
//   arb_state_e : arbiter FSM states (IDLE -> BUSY -> GAP -> IDLE)
//   OWN_TCPM    : owner encoding for the I2C slave manager side
//   OWN_LCL     : owner encoding for local TCPC logic
package tcpc_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_GAP  = 2'd2
    } arb_state_e;

    localparam logic OWN_TCPM = 1'b0;
    localparam logic OWN_LCL  = 1'b1;

endpackage

// File: rtl/tcpc_rr_pick.sv
// Combinational 2-way round-robin picker.
//   req[0]      : tcpm request
//   req[1]      : lcl request
//   last_owner  : owner of the previous completed transaction
//   grant_valid : at least one request present
//   grant_id    : chosen owner (OWN_TCPM / OWN_LCL)
module tcpc_rr_pick
    import tcpc_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_owner,
    output logic       grant_valid,
    output logic       grant_id
);

    // A tie goes to whoever did not own the port last.
    always_comb begin
        grant_valid = |req;
        grant_id    = OWN_TCPM;
        case (req)
            2'b01:   grant_id = OWN_TCPM;
            2'b10:   grant_id = OWN_LCL;
            2'b11:   grant_id = ~last_owner;
            default: grant_id = OWN_TCPM;
        endcase
    end

endmodule

// File: rtl/tcpc_regs_arbiter.sv
// Two-requester arbiter for the single TCPC register-file access port.
// Shares the port between the TCPM-side I2C slave manager ("tcpm") and
// local TCPC logic ("lcl"); round-robin, one transaction at a time.
// Optional build macro: TCPC_ARB_TIMEOUT_EN (BUSY gives up after
// TIMEOUT_CYCLES without ACK_reg and pulses ERR_x to the owner).
// Ports:
//   CLK, RESET_N                 clock, synchronous active-low reset
//   REQ/RNW/ADDR/WR_DATA_tcpm    TCPM request (REQ held until ACK_tcpm)
//   ACK/RD_DATA/ERR_tcpm         TCPM response
//   REQ/RNW/ADDR/WR_DATA_lcl     local-logic request
//   ACK/RD_DATA/ERR_lcl          local-logic response
//   REQ/RNW/ADDR/WR_DATA_reg     registered request to the register file
//   RD_DATA_reg, ACK_reg         register-file response
//   BUSY, OWNER                  transaction in flight / its owner (0=tcpm)
module tcpc_regs_arbiter #(
    parameter int unsigned ADDR_W         = 8,
    parameter int unsigned DATA_W         = 8,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              REQ_tcpm,
    input  logic              RNW_tcpm,
    input  logic [ADDR_W-1:0] ADDR_tcpm,
    input  logic [DATA_W-1:0] WR_DATA_tcpm,
    output logic              ACK_tcpm,
    output logic [DATA_W-1:0] RD_DATA_tcpm,
    output logic              ERR_tcpm,
    input  logic              REQ_lcl,
    input  logic              RNW_lcl,
    input  logic [ADDR_W-1:0] ADDR_lcl,
    input  logic [DATA_W-1:0] WR_DATA_lcl,
    output logic              ACK_lcl,
    output logic [DATA_W-1:0] RD_DATA_lcl,
    output logic              ERR_lcl,
    output logic              REQ_reg,
    output logic              RNW_reg,
    output logic [ADDR_W-1:0] ADDR_reg,
    output logic [DATA_W-1:0] WR_DATA_reg,
    input  logic [DATA_W-1:0] RD_DATA_reg,
    input  logic              ACK_reg,
    output logic              BUSY,
    output logic              OWNER
);

    import tcpc_arb_pkg::*;

    if (TIMEOUT_CYCLES < 1) begin : g_timeout_check
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    arb_state_e        state_q, state_d;
    logic              owner_q, owner_d;
    logic              last_owner_q, last_owner_d;
    logic              req_reg_q, req_reg_d;
    logic              rnw_reg_q, rnw_reg_d;
    logic [ADDR_W-1:0] addr_reg_q, addr_reg_d;
    logic [DATA_W-1:0] wr_data_reg_q, wr_data_reg_d;
    logic              grant_valid_c;
    logic              grant_id_c;
    logic              busy_c;
    logic              timeout_c;

    assign busy_c = (state_q == ST_BUSY);

    tcpc_rr_pick u_pick (
        .req         ({REQ_lcl, REQ_tcpm}),
        .last_owner  (last_owner_q),
        .grant_valid (grant_valid_c),
        .grant_id    (grant_id_c)
    );

`ifdef TCPC_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cnt_inc_c;
    logic             err_tcpm_q, err_tcpm_d;
    logic             err_lcl_q, err_lcl_d;

    // Expiry is the BUSY cycle whose count would reach the limit; an ACK in
    // that same cycle takes precedence.
    assign cnt_inc_c = cnt_q + CNT_W'(1);
    assign timeout_c = busy_c && !ACK_reg && (cnt_inc_c == CNT_W'(TIMEOUT_CYCLES));
    assign ERR_tcpm  = err_tcpm_q;
    assign ERR_lcl   = err_lcl_q;
`else
    assign timeout_c = 1'b0;
    assign ERR_tcpm  = 1'b0;
    assign ERR_lcl   = 1'b0;
`endif

    // State and output registers.
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state_q       <= ST_IDLE;
            owner_q       <= OWN_TCPM;
            last_owner_q  <= OWN_LCL;
            req_reg_q     <= 1'b0;
            rnw_reg_q     <= 1'b0;
            addr_reg_q    <= '0;
            wr_data_reg_q <= '0;
`ifdef TCPC_ARB_TIMEOUT_EN
            cnt_q         <= '0;
            err_tcpm_q    <= 1'b0;
            err_lcl_q     <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            owner_q       <= owner_d;
            last_owner_q  <= last_owner_d;
            req_reg_q     <= req_reg_d;
            rnw_reg_q     <= rnw_reg_d;
            addr_reg_q    <= addr_reg_d;
            wr_data_reg_q <= wr_data_reg_d;
`ifdef TCPC_ARB_TIMEOUT_EN
            cnt_q         <= cnt_d;
            err_tcpm_q    <= err_tcpm_d;
            err_lcl_q     <= err_lcl_d;
`endif
        end
    end

    // Next-state: grant in IDLE, hold in BUSY, one dead cycle in GAP.
    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        last_owner_d  = last_owner_q;
        req_reg_d     = req_reg_q;
        rnw_reg_d     = rnw_reg_q;
        addr_reg_d    = addr_reg_q;
        wr_data_reg_d = wr_data_reg_q;
`ifdef TCPC_ARB_TIMEOUT_EN
        cnt_d         = cnt_q;
        err_tcpm_d    = 1'b0;
        err_lcl_d     = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (grant_valid_c) begin
                    state_d   = ST_BUSY;
                    owner_d   = grant_id_c;
                    req_reg_d = 1'b1;
                    if (grant_id_c == OWN_LCL) begin
                        rnw_reg_d     = RNW_lcl;
                        addr_reg_d    = ADDR_lcl;
                        wr_data_reg_d = WR_DATA_lcl;
                    end else begin
                        rnw_reg_d     = RNW_tcpm;
                        addr_reg_d    = ADDR_tcpm;
                        wr_data_reg_d = WR_DATA_tcpm;
                    end
`ifdef TCPC_ARB_TIMEOUT_EN
                    cnt_d = '0;
`endif
                end
            end
            ST_BUSY: begin
`ifdef TCPC_ARB_TIMEOUT_EN
                cnt_d = cnt_inc_c;
`endif
                if (ACK_reg || timeout_c) begin
                    state_d      = ST_GAP;
                    req_reg_d    = 1'b0;
                    last_owner_d = owner_q;
`ifdef TCPC_ARB_TIMEOUT_EN
                    err_tcpm_d   = timeout_c && (owner_q == OWN_TCPM);
                    err_lcl_d    = timeout_c && (owner_q == OWN_LCL);
`endif
                end
            end
            ST_GAP:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Response routing is combinational so the owner sees ACK in the same
    // cycle as the register file.
    assign ACK_tcpm     = ACK_reg && busy_c && (owner_q == OWN_TCPM);
    assign ACK_lcl      = ACK_reg && busy_c && (owner_q == OWN_LCL);
    assign RD_DATA_tcpm = ACK_tcpm ? RD_DATA_reg : '0;
    assign RD_DATA_lcl  = ACK_lcl ? RD_DATA_reg : '0;

    assign REQ_reg     = req_reg_q;
    assign RNW_reg     = rnw_reg_q;
    assign ADDR_reg    = addr_reg_q;
    assign WR_DATA_reg = wr_data_reg_q;
    assign BUSY        = busy_c;
    assign OWNER       = owner_q;

endmodule

// File: tb/tb_tcpc_regs_arbiter.sv
// Self-checking bench for tcpc_regs_arbiter: protocol-following requester
// agents, a register-file responder, a transaction-level reference model and
// literal expectations for the directed scenarios.
module tb_tcpc_regs_arbiter;

`ifdef TCPC_ARB_TIMEOUT_EN
    localparam int unsigned TO = 4;
`else
    localparam int unsigned TO = 16;
`endif

    typedef struct packed {
        logic       rnw;
        logic [7:0] addr;
        logic [7:0] wd;
    } txn_t;

    logic       CLK, RESET_N;
    logic       REQ_tcpm, RNW_tcpm, ACK_tcpm, ERR_tcpm;
    logic [7:0] ADDR_tcpm, WR_DATA_tcpm, RD_DATA_tcpm;
    logic       REQ_lcl, RNW_lcl, ACK_lcl, ERR_lcl;
    logic [7:0] ADDR_lcl, WR_DATA_lcl, RD_DATA_lcl;
    logic       REQ_reg, RNW_reg, ACK_reg, BUSY, OWNER;
    logic [7:0] ADDR_reg, WR_DATA_reg, RD_DATA_reg;

    tcpc_regs_arbiter #(.ADDR_W(8), .DATA_W(8), .TIMEOUT_CYCLES(TO)) dut (
        .CLK(CLK), .RESET_N(RESET_N),
        .REQ_tcpm(REQ_tcpm), .RNW_tcpm(RNW_tcpm), .ADDR_tcpm(ADDR_tcpm),
        .WR_DATA_tcpm(WR_DATA_tcpm), .ACK_tcpm(ACK_tcpm),
        .RD_DATA_tcpm(RD_DATA_tcpm), .ERR_tcpm(ERR_tcpm),
        .REQ_lcl(REQ_lcl), .RNW_lcl(RNW_lcl), .ADDR_lcl(ADDR_lcl),
        .WR_DATA_lcl(WR_DATA_lcl), .ACK_lcl(ACK_lcl),
        .RD_DATA_lcl(RD_DATA_lcl), .ERR_lcl(ERR_lcl),
        .REQ_reg(REQ_reg), .RNW_reg(RNW_reg), .ADDR_reg(ADDR_reg),
        .WR_DATA_reg(WR_DATA_reg), .RD_DATA_reg(RD_DATA_reg),
        .ACK_reg(ACK_reg), .BUSY(BUSY), .OWNER(OWNER)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- stimulus state ----------------
    txn_t       q_t[$];
    txn_t       q_l[$];
    bit         act_t = 0, act_l = 0;
    bit         linger = 0, scramble = 0, resp_en = 1;
    int         resp_delay = 2;
    logic [7:0] rd_t, rd_l;
    logic [7:0] mem [256];

    function automatic txn_t mk(input logic rnw, input logic [7:0] addr, input logic [7:0] wd);
        txn_t t;
        t.rnw = rnw; t.addr = addr; t.wd = wd;
        return t;
    endfunction

    task automatic drive(input bit port, input logic req, input txn_t t);
        if (port) begin
            REQ_lcl = req; RNW_lcl = t.rnw; ADDR_lcl = t.addr; WR_DATA_lcl = t.wd;
        end else begin
            REQ_tcpm = req; RNW_tcpm = t.rnw; ADDR_tcpm = t.addr; WR_DATA_tcpm = t.wd;
        end
    endtask

    // Requester: raise REQ, hold until ACK/ERR (or reset), then drop it.
    task automatic run_agent(input bit port);
        txn_t t, s;
        bit   got, ack, err;
        forever begin
            @(posedge CLK); #1;
            if (RESET_N && (port ? q_l.size() : q_t.size()) > 0) begin
                if (port) begin t = q_l.pop_front(); act_l = 1; end
                else      begin t = q_t.pop_front(); act_t = 1; end
                drive(port, 1'b1, t);
                got = 0;
                for (int i = 0; i < 64 && !got; i++) begin
                    @(negedge CLK); #2;
                    ack = port ? ACK_lcl : ACK_tcpm;
                    err = port ? ERR_lcl : ERR_tcpm;
                    if (ack) begin
                        got = 1;
                        if (port) rd_l = RD_DATA_lcl; else rd_t = RD_DATA_tcpm;
                    end else if (err || !RESET_N) begin
                        got = 1;
                    end else if (scramble && i == 1) begin
                        s = mk(~t.rnw, ~t.addr, ~t.wd);
                        drive(port, 1'b1, s);
                    end
                end
                chk(port ? "agent_lcl_done" : "agent_tcpm_done", 32'(got), 32'd1);
                @(posedge CLK); #1;
                if (linger) begin @(posedge CLK); #1; end
                drive(port, 1'b0, t);
                if (port) act_l = 0; else act_t = 0;
            end
        end
    endtask

    initial run_agent(1'b0);
    initial run_agent(1'b1);

    // Register file: ACK in the resp_delay-th cycle of REQ_reg; garbage on
    // RD_DATA_reg otherwise so routing must gate it.
    initial begin : responder
        int rcnt;
        rcnt = 0;
        ACK_reg = 1'b0;
        RD_DATA_reg = 8'hEE;
        forever begin
            @(negedge CLK);
            if (REQ_reg === 1'b1 && resp_en) begin
                rcnt++;
                if (rcnt == resp_delay) begin
                    ACK_reg = 1'b1;
                    if (RNW_reg) RD_DATA_reg = mem[ADDR_reg];
                    else begin mem[ADDR_reg] = WR_DATA_reg; RD_DATA_reg = 8'h77; end
                end else begin
                    ACK_reg = 1'b0; RD_DATA_reg = 8'hEE;
                end
            end else begin
                rcnt = 0; ACK_reg = 1'b0; RD_DATA_reg = 8'hEE;
            end
        end
    end

    // ---------------- reference model ----------------
    // m_own: -1 when no transaction is granted; m_hold: edges to skip after
    // a completion before a new grant may happen.
    int         m_own = -1, m_hold = 0, m_last = 1, m_cnt = 0, m_pick;
    logic       m_rnw;
    logic [7:0] m_addr, m_wd;
    bit         m_err_t = 0, m_err_l = 0, m_started = 0;

    initial forever begin
        @(posedge CLK);
        m_err_t = 0; m_err_l = 0;
        if (RESET_N !== 1'b1) begin
            m_own = -1; m_hold = 0; m_last = 1; m_cnt = 0; m_started = 1;
        end else if (m_own >= 0) begin
            m_cnt++;
            if (ACK_reg) begin
                m_last = m_own; m_own = -1; m_hold = 1;
            end
`ifdef TCPC_ARB_TIMEOUT_EN
            else if (m_cnt >= TO) begin
                if (m_own == 0) m_err_t = 1; else m_err_l = 1;
                m_last = m_own; m_own = -1; m_hold = 1;
            end
`endif
        end else if (m_hold > 0) begin
            m_hold--;
        end else if (REQ_tcpm || REQ_lcl) begin
            if (REQ_tcpm && REQ_lcl) m_pick = 1 - m_last;
            else                     m_pick = REQ_lcl ? 1 : 0;
            m_own = m_pick; m_cnt = 0;
            if (m_pick == 1) begin m_rnw = RNW_lcl;  m_addr = ADDR_lcl;  m_wd = WR_DATA_lcl;  end
            else             begin m_rnw = RNW_tcpm; m_addr = ADDR_tcpm; m_wd = WR_DATA_tcpm; end
        end
    end

    // ---------------- per-cycle compare + monitor ----------------
    int         cyc = 0, n_ack_t = 0, n_ack_l = 0, n_err_t = 0, n_err_l = 0, n_txn = 0;
    int         rise_cyc = 0, err_cyc = 0;
    bit         prev_req = 0;
    int         glog[$];
    logic [7:0] alog[$];
    logic [7:0] wlog[$];

    initial forever begin
        logic busy_e, ack_t_e, ack_l_e;
        @(negedge CLK); #1;
        cyc++;
        if (m_started) begin
            busy_e  = (m_own >= 0);
            ack_t_e = ACK_reg && (m_own == 0);
            ack_l_e = ACK_reg && (m_own == 1);
            chk("busy", 32'(BUSY), 32'(busy_e));
            chk("req_reg", 32'(REQ_reg), 32'(busy_e));
            chk("ack_tcpm", 32'(ACK_tcpm), 32'(ack_t_e));
            chk("ack_lcl", 32'(ACK_lcl), 32'(ack_l_e));
            chk("rd_tcpm", 32'(RD_DATA_tcpm), ack_t_e ? 32'(RD_DATA_reg) : 32'd0);
            chk("rd_lcl", 32'(RD_DATA_lcl), ack_l_e ? 32'(RD_DATA_reg) : 32'd0);
            chk("err_tcpm", 32'(ERR_tcpm), 32'(m_err_t));
            chk("err_lcl", 32'(ERR_lcl), 32'(m_err_l));
            if (busy_e) begin
                chk("owner", 32'(OWNER), 32'(m_own));
                chk("rnw_reg", 32'(RNW_reg), 32'(m_rnw));
                chk("addr_reg", 32'(ADDR_reg), 32'(m_addr));
                chk("wr_data_reg", 32'(WR_DATA_reg), 32'(m_wd));
            end
        end
        if (ACK_tcpm === 1'b1) n_ack_t++;
        if (ACK_lcl === 1'b1)  n_ack_l++;
        if (ERR_tcpm === 1'b1) begin n_err_t++; err_cyc = cyc; end
        if (ERR_lcl === 1'b1)  n_err_l++;
        if (REQ_reg === 1'b1 && !prev_req) begin
            n_txn++; rise_cyc = cyc;
            glog.push_back(int'(OWNER)); alog.push_back(ADDR_reg); wlog.push_back(WR_DATA_reg);
        end
        prev_req = (REQ_reg === 1'b1);
    end

    // ---------------- directed sequence ----------------
    task automatic wait_idle();
        bit done;
        done = 0;
        for (int i = 0; i < 400 && !done; i++) begin
            @(posedge CLK); #1;
            if (q_t.size() == 0 && q_l.size() == 0 && !act_t && !act_l) done = 1;
        end
        chk("wait_idle", 32'(done), 32'd1);
        repeat (4) @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        @(posedge CLK); #1;
        RESET_N = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        RESET_N = 1'b1;
    endtask

    initial begin
        int         b_t, b_l, b_txn, b_g, b_et;
        int         exp3[5];
        bit         seen;
        exp3 = '{0, 1, 0, 1, 0};
        for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h5A;
        mem[8'h1D] = 8'h3C;
        RESET_N = 1'b0;
        drive(1'b0, 1'b0, mk(1'b0, 8'h00, 8'h00));
        drive(1'b1, 1'b0, mk(1'b0, 8'h00, 8'h00));

        // Reset state while reset is held.
        repeat (2) @(posedge CLK);
        @(negedge CLK); #2;
        chk("rst_busy", 32'(BUSY), 32'd0);
        chk("rst_req_reg", 32'(REQ_reg), 32'd0);
        chk("rst_owner", 32'(OWNER), 32'd0);
        chk("rst_rnw_reg", 32'(RNW_reg), 32'd0);
        chk("rst_addr_reg", 32'(ADDR_reg), 32'd0);
        chk("rst_wr_data_reg", 32'(WR_DATA_reg), 32'd0);
        chk("rst_ack", 32'({ACK_tcpm, ACK_lcl}), 32'd0);
        chk("rst_err", 32'({ERR_tcpm, ERR_lcl}), 32'd0);
        @(posedge CLK); #1;
        RESET_N = 1'b1;

        // 1: tcpm write, upstream fields scrambled after the grant.
        b_t = n_ack_t; b_l = n_ack_l; b_txn = n_txn; b_g = glog.size();
        resp_delay = 2; scramble = 1;
        q_t.push_back(mk(1'b0, 8'h10, 8'hA5));
        wait_idle();
        scramble = 0;
        chk("t1_txn", 32'(n_txn - b_txn), 32'd1);
        chk("t1_ack_tcpm", 32'(n_ack_t - b_t), 32'd1);
        chk("t1_ack_lcl", 32'(n_ack_l - b_l), 32'd0);
        chk("t1_addr", 32'(alog[b_g]), 32'h10);
        chk("t1_wdata", 32'(wlog[b_g]), 32'hA5);
        chk("t1_mem", 32'(mem[8'h10]), 32'hA5);

        // 2: lcl read of 0x1D.
        b_t = n_ack_t; b_l = n_ack_l;
        q_l.push_back(mk(1'b1, 8'h1D, 8'h00));
        wait_idle();
        chk("t2_ack_lcl", 32'(n_ack_l - b_l), 32'd1);
        chk("t2_ack_tcpm", 32'(n_ack_t - b_t), 32'd0);
        chk("t2_rd_lcl", 32'(rd_l), 32'h3C);

        // 3: both requesting from reset exit -> strict alternation.
        do_reset();
        b_g = glog.size();
        resp_delay = 1;
        q_t.push_back(mk(1'b0, 8'h30, 8'h01));
        q_t.push_back(mk(1'b0, 8'h31, 8'h02));
        q_t.push_back(mk(1'b0, 8'h32, 8'h03));
        q_l.push_back(mk(1'b1, 8'h1D, 8'h00));
        q_l.push_back(mk(1'b1, 8'h40, 8'h00));
        wait_idle();
        chk("t3_grants", 32'(glog.size() - b_g), 32'd5);
        if (glog.size() >= b_g + 5)
            for (int i = 0; i < 5; i++) chk("t3_order", 32'(glog[b_g + i]), 32'(exp3[i]));

        // 4: requester holds REQ through the GAP cycle -> one transaction.
        b_txn = n_txn; b_t = n_ack_t;
        resp_delay = 2; linger = 1;
        q_t.push_back(mk(1'b0, 8'h22, 8'h5C));
        wait_idle();
        repeat (6) @(posedge CLK);
        linger = 0;
        chk("t4_txn", 32'(n_txn - b_txn), 32'd1);
        chk("t4_ack", 32'(n_ack_t - b_t), 32'd1);

        // 5: reset while BUSY, then a normal grant.
        b_t = n_ack_t;
        resp_en = 0;
        q_t.push_back(mk(1'b0, 8'h55, 8'h66));
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin @(negedge CLK); #2; if (BUSY) seen = 1; end
        chk("t5_busy_seen", 32'(seen), 32'd1);
        @(posedge CLK); #1;
        RESET_N = 1'b0;
        @(negedge CLK); #2;
        chk("t5_no_ack", 32'(ACK_tcpm), 32'd0);
        @(posedge CLK); #1;
        RESET_N = 1'b1;
        @(negedge CLK); #2;
        chk("t5_req_reg_low", 32'(REQ_reg), 32'd0);
        chk("t5_busy_low", 32'(BUSY), 32'd0);
        wait_idle();
        chk("t5_ack_count", 32'(n_ack_t - b_t), 32'd0);
        resp_en = 1;
        b_l = n_ack_l;
        q_l.push_back(mk(1'b1, 8'h1D, 8'h00));
        wait_idle();
        chk("t5_regrant_ack", 32'(n_ack_l - b_l), 32'd1);
        chk("t5_regrant_rd", 32'(rd_l), 32'h3C);

`ifdef TCPC_ARB_TIMEOUT_EN
        // 6: no ACK -> ERR 4 cycles after grant; ACK on expiry cycle wins.
        b_t = n_ack_t; b_et = n_err_t;
        resp_en = 0;
        q_t.push_back(mk(1'b0, 8'h60, 8'h61));
        wait_idle();
        chk("t6_err", 32'(n_err_t - b_et), 32'd1);
        chk("t6_err_no_ack", 32'(n_ack_t - b_t), 32'd0);
        chk("t6_err_latency", 32'(err_cyc - rise_cyc), 32'd4);
        resp_en = 1; resp_delay = 4;
        b_t = n_ack_t; b_et = n_err_t;
        q_t.push_back(mk(1'b0, 8'h61, 8'h62));
        wait_idle();
        chk("t6_expiry_ack", 32'(n_ack_t - b_t), 32'd1);
        chk("t6_expiry_no_err", 32'(n_err_t - b_et), 32'd0);
`else
        chk("no_err_pulses", 32'(n_err_t + n_err_l), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        failures++;
        $display("FAIL watchdog: simulation did not finish in time");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

endmodule
